sram_controller: RTL and testbench
==================================

# sram_controller

Initiator-side access engine for the 32-word data SRAM. It accepts single-word read, single-word write and multi-word copy commands over a valid/ready command port. It sequences the SRAM's `memRead`, `memWrite`, `address` and `writeData` pins, and returns one registered response per command. It sits between the datapath's memory stage and the SRAM, so the datapath never drives SRAM pins directly.

## Interface
- `ADDR_BITS`, 5: SRAM index width; depth is 2^ADDR_BITS words. Addresses are taken modulo depth.
- `DATA_WIDTH`, 32: word width.

- `clock`  in  1  rising-edge clock
- `nReset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE; command accepted on a clock edge where `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 read, 01 write, 10 copy, 11 reserved
- `cmd_addr`  in  32  read/write address; copy source base
- `cmd_dst`  in  32  copy destination base; ignored otherwise
- `cmd_len`  in  6  copy word count, legal 1..32; ignored otherwise
- `cmd_wdata`  in  DATA_WIDTH  write data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_WIDTH  read result; for copy, the last word copied
- `resp_err`  out  1  qualifies `resp_valid`; illegal command
- `busy`  out  1  equals `!cmd_ready`
- `memAddress`  out  32  to SRAM `address`; bits [31:ADDR_BITS] always 0
- `memWriteData`  out  DATA_WIDTH  to SRAM `writeData`
- `memWrite`  out  1  to SRAM `memWrite`
- `memRead`  out  1  to SRAM `memRead`
- `memReadData`  in  DATA_WIDTH  from SRAM `readData`; valid only while `memRead` is high

## Operation
- **Command capture.** All `cmd_*` fields are registered on acceptance. Inputs are don't-care afterwards.
- **States:** IDLE, RD, WR, CP_RD, CP_WR, DONE.
- **IDLE:**
  - on accept, read goes to RD and write goes to WR.
  - on accept, a legal copy goes to CP_RD with count = `cmd_len`.
  - op 11, or copy with `cmd_len` of 0 or greater than 32, goes to DONE with the error flag set and makes no SRAM access.
- **RD:**
  - drives `memRead`=1 and `memAddress`=addr.
  - on the edge, loads `resp_rdata` from `memReadData` and goes to DONE.
- **WR:** drives `memWrite`=1, `memAddress`=addr, `memWriteData`=wdata; goes to DONE.
- **CP_RD:**
  - drives `memRead`=1 and `memAddress`=src.
  - on the edge, latches `memReadData` into the copy buffer and into `resp_rdata`, then goes to CP_WR.
- **CP_WR:**
  - drives `memWrite`=1, `memAddress`=dst, `memWriteData`=buffer.
  - on the edge, src+1, dst+1 (both mod depth) and count−1.
  - goes to DONE if count was 1, else to CP_RD.
- **DONE:** `resp_valid`=1 and `resp_err`=error flag for exactly this cycle; then to IDLE.
- **Copy order.** Copy is strictly ascending, one word read then written before the next read. Overlapping regions behave per that order; e.g. dst=src+1 replicates `mem[src]`.
- **Address wrap.** Source and destination wrap independently from 31 to 0.
- **Pin rules.**
  - `memRead` and `memWrite` are never both high.
  - Both are 0 in IDLE, DONE and reset.
  - `memAddress` and `memWriteData` are 0 whenever the corresponding strobe is inactive.
- **`resp_rdata` retention.** Holds its value until the next RD or CP_RD capture. Write and error responses leave it unchanged.

## Timing
- **Reset values.** `nReset` low asynchronously forces:
  - state IDLE, `cmd_ready`=1, `busy`=0;
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0;
  - all `mem*` outputs 0.
- **Reset mid-operation.** Reset during a copy truncates it; words already written remain. No response is produced for the aborted command.
- **Latency.** Counted in cycles from the accept edge to `resp_valid`:
  - read and write: 2 (RD/WR, then DONE);
  - error: 1;
  - copy of N words: 2N+1.
- **Throughput.** Commands are accepted only in IDLE, so back-to-back read/write issue every 3 cycles.
- **Valid/ready rule.** `cmd_valid` may assert at any time. A command held while `cmd_ready`=0 is accepted on the first IDLE edge.

## Test plan
- **Reset defaults.** SRAM preloaded with mem[0..5]=7,5,2,4,8,4; read addr 3 → `resp_rdata`=4 with `resp_valid` 2 cycles after accept; `memRead` high exactly 1 cycle.
- **Write then read.** Write addr 10 data 0xDEADBEEF, then read addr 10 → 0xDEADBEEF; `memWrite` high 1 cycle; read addr 42 returns mem[10].
- **Copy with wrap.** Copy src 0, dst 30, len 4 → mem[30],[31],[0],[1] = 7,5,2,4 ... mem[0] overwritten after being read; `resp_valid` 9 cycles after accept; `resp_rdata`=4.
- **Overlapping copy and illegal ops.**
  - Copy src 0, dst 1, len 3 → mem[1..3]=7,7,7.
  - Copy len 0 → `resp_err`=1 after 1 cycle, no strobes.
  - Op 11 → `resp_err`=1 after 1 cycle, no strobes.
- **Reset mid-copy.** Assert `nReset` low during the 3rd CP_WR of a len-8 copy → outputs reset immediately; exactly 2 words modified (the in-flight third write is lost if reset precedes its edge); no `resp_valid`.
- **Held command.** `cmd_valid` held high with a read while busy with a copy → accepted on the first IDLE edge; `memRead`/`memWrite` never both high throughout.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: initiator-side access engine for the data SRAM.
// Accepts single-word read, single-word write and multi-word copy commands
// over a valid/ready port, sequences the SRAM strobes and returns one
// response pulse per command.
//
// Ports:
//   clock, nReset          clock and asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_op                 00 read, 01 write, 10 copy, 11 reserved
//   cmd_addr, cmd_dst      word address / copy source, copy destination
//   cmd_len, cmd_wdata     copy word count (1..depth), write data
//   resp_valid/_rdata/_err one-cycle completion pulse, read data, error
//   busy                   inverse of cmd_ready
//   memAddress, memWriteData, memWrite, memRead, memReadData   SRAM pins
module sram_controller #(
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_dst,
  input  logic [5:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic [31:0]           memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memWrite,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam int unsigned LEN_W = 6;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_CP_RD,
    S_CP_WR,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   src_q, src_d;
  logic [ADDR_BITS-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  // Shared data register: write data for WR, copy buffer for CP_RD/CP_WR.
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  // Upper address bits are discarded: addresses wrap modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmd_addr[31:ADDR_BITS], cmd_dst[31:ADDR_BITS]};

  // State and datapath registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_addr[ADDR_BITS-1:0];
          dst_d  = cmd_dst[ADDR_BITS-1:0];
          cnt_d  = cmd_len;
          data_d = cmd_wdata;
          err_d  = 1'b0;
          unique case (cmd_op)
            OP_RD: state_d = S_RD;
            OP_WR: state_d = S_WR;
            OP_CP: begin
              if (cmd_len == '0 || 32'(cmd_len) > DEPTH) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_CP_RD;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RD: begin
        rdata_d = memReadData;
        state_d = S_DONE;
      end
      S_WR: state_d = S_DONE;
      S_CP_RD: begin
        data_d  = memReadData;
        rdata_d = memReadData;
        state_d = S_CP_WR;
      end
      S_CP_WR: begin
        src_d   = src_q + ADDR_BITS'(1);
        dst_d   = dst_q + ADDR_BITS'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_CP_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // SRAM pin decode: address and write data are zero whenever their strobe is idle.
  always_comb begin
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    unique case (state_q)
      S_RD, S_CP_RD: begin
        memRead    = 1'b1;
        memAddress = 32'(src_q);
      end
      S_WR: begin
        memWrite     = 1'b1;
        memAddress   = 32'(src_q);
        memWriteData = data_q;
      end
      S_CP_WR: begin
        memWrite     = 1'b1;
        memAddress   = 32'(dst_q);
        memWriteData = data_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = (state_q == S_DONE) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a 32-word SRAM, a command-level memory model
// and a per-cycle checker of strobes, pin rules and responses.
module tb_sram_controller;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;

  logic          clock;
  logic          nReset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_addr;
  logic [31:0]   cmd_dst;
  logic [5:0]    cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;
  logic [31:0]   memAddress;
  logic [DW-1:0] memWriteData;
  logic          memWrite;
  logic          memRead;
  logic [DW-1:0] memReadData;

  sram_controller #(.ADDR_BITS(5), .DATA_WIDTH(DW)) dut (
    .clock(clock), .nReset(nReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
    .memRead(memRead), .memReadData(memReadData)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // SRAM: combinational read while memRead, write on the clock edge.
  logic [31:0] mem      [DEPTH];
  logic [31:0] init_mem [DEPTH];
  logic        init_done;
  assign memReadData = memRead ? mem[memAddress[4:0]] : '0;
  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_mem[i];
    end else if (memWrite) begin
      mem[memAddress[4:0]] <= memWriteData;
    end
  end

  // Command-level reference model.
  typedef struct { bit wr; logic [4:0] a; logic [31:0] d; } strobe_t;
  typedef struct { logic [31:0] rdata; bit err; int cyc; } resp_t;
  strobe_t     sq[$];
  resp_t       rq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected strobe sequence and response for one accepted command.
  // abort_at >= 0: reset hits during that copy word's write, nothing after it lands.
  task automatic model_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [5:0] len, input logic [31:0] wd, input int acc,
                           input int abort_at);
    strobe_t s; resp_t r; int lat; logic [4:0] sa, da; logic [31:0] v;
    r.err = 1'b0;
    lat   = 2;
    case (op)
      2'b00: begin
        s.wr = 1'b0; s.a = 5'(a % DEPTH); s.d = '0; sq.push_back(s);
        last_rdata = ref_mem[s.a];
      end
      2'b01: begin
        s.wr = 1'b1; s.a = 5'(a % DEPTH); s.d = wd; sq.push_back(s);
        ref_mem[s.a] = wd;
      end
      2'b10: begin
        if (int'(len) == 0 || int'(len) > 32) begin
          r.err = 1'b1; lat = 1;
        end else begin
          lat = 2 * int'(len) + 1;
          for (int i = 0; i < int'(len); i++) begin
            sa = 5'((a + 32'(i)) % DEPTH);
            da = 5'((d + 32'(i)) % DEPTH);
            v  = ref_mem[sa];
            s.wr = 1'b0; s.a = sa; s.d = '0; sq.push_back(s);
            s.wr = 1'b1; s.a = da; s.d = v;  sq.push_back(s);
            if (i == abort_at) break;
            ref_mem[da] = v;
            last_rdata  = v;
          end
        end
      end
      default: begin
        r.err = 1'b1; lat = 1;
      end
    endcase
    r.rdata = last_rdata;
    r.cyc   = acc + lat;
    if (abort_at < 0) rq.push_back(r);
  endtask

  // Per-cycle checker.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] seen_rdata;
  logic        seen_err;
  int          seen_cyc;
  strobe_t     cs;
  resp_t       cr;
  always @(negedge clock) begin
    if (nReset) begin
      chk("rd_wr_exclusive", 32'(memRead & memWrite), 32'd0);
      chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
      chk("addr_high_bits", 32'(memAddress[31:5]), 32'd0);
      chk("addr_idle_zero", (memRead | memWrite) ? 32'd0 : memAddress, 32'd0);
      chk("wdata_idle_zero", memWrite ? 32'd0 : memWriteData, 32'd0);
      chk("err_qualified", 32'(resp_err & !resp_valid), 32'd0);
      if (memRead || memWrite) begin
        if (memRead)  rd_cnt++;
        if (memWrite) wr_cnt++;
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: rd=%0b wr=%0b addr=%0d, required no strobe",
                   memRead, memWrite, memAddress);
        end else begin
          cs = sq.pop_front();
          chk("strobe_kind", 32'(memWrite), 32'(cs.wr));
          chk("strobe_addr", memAddress, 32'(cs.a));
          if (cs.wr) chk("strobe_wdata", memWriteData, cs.d);
        end
      end
      if (resp_valid) begin
        seen_rdata = resp_rdata;
        seen_err   = resp_err;
        seen_cyc   = cyc;
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          cr = rq.pop_front();
          chk("resp_rdata", resp_rdata, cr.rdata);
          chk("resp_err", 32'(resp_err), 32'(cr.err));
          chk("resp_cycle", 32'(cyc), 32'(cr.cyc));
        end
      end
    end
  end

  // Presents a command, waits for acceptance (bounded) and records the model.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [5:0] len, input logic [31:0] wd, input int abort_at,
                       output int acc);
    int n;
    @(negedge clock);
    cmd_op = op; cmd_addr = a; cmd_dst = d; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", n);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clock);
    #1;
    acc = cyc - 1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_dst = $urandom;
    cmd_len = 6'($urandom); cmd_wdata = $urandom;
    model_cmd(op, a, d, len, wd, acc, abort_at);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rq.size() != 0 || sq.size() != 0) && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (rq.size() != 0 || sq.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: %0d responses and %0d strobes outstanding, required 0",
               rq.size(), sq.size());
      rq.delete();
      sq.delete();
    end
  endtask

  logic [31:0] pre [6];
  logic [31:0] snap [DEPTH];

  initial begin
    int acc, acc2, r0, w0, diffs;
    logic [1:0] op;
    pre = '{32'd7, 32'd5, 32'd2, 32'd4, 32'd8, 32'd4};
    nReset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_dst = '0;
    cmd_len = '0; cmd_wdata = '0; init_done = 1'b0; last_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++)
      init_mem[i] = (i < 6) ? pre[i] : {8'(8'h40 + i), 24'($urandom)};
    ref_mem = init_mem;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    chk("rst_ctrl", 32'({cmd_ready, busy, resp_valid, resp_err, memRead, memWrite}), 32'b100000);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", memAddress, 32'd0);
    chk("rst_wdata", memWriteData, 32'd0);
    init_done = 1'b1;
    @(negedge clock);
    #2 nReset = 1'b1;

    // Read of a preloaded word.
    r0 = rd_cnt;
    issue(2'b00, 32'd3, 32'd0, 6'd0, 32'd0, -1, acc);
    wait_done();
    chk("rd3_rdata", seen_rdata, 32'd4);
    chk("rd3_latency", 32'(seen_cyc - acc), 32'd2);
    chk("rd3_memread_cycles", 32'(rd_cnt - r0), 32'd1);

    // Write then read back, including an aliased address.
    w0 = wr_cnt;
    issue(2'b01, 32'd10, 32'd0, 6'd0, 32'hDEADBEEF, -1, acc);
    wait_done();
    chk("wr10_memwrite_cycles", 32'(wr_cnt - w0), 32'd1);
    chk("wr10_sram", mem[10], 32'hDEADBEEF);
    chk("wr_keeps_rdata", seen_rdata, 32'd4);
    chk("wr_latency", 32'(seen_cyc - acc), 32'd2);
    issue(2'b00, 32'd10, 32'd0, 6'd0, 32'd0, -1, acc);
    wait_done();
    chk("rd10_rdata", seen_rdata, 32'hDEADBEEF);
    issue(2'b00, 32'd42, 32'd0, 6'd0, 32'd0, -1, acc);
    wait_done();
    chk("rd42_alias", seen_rdata, 32'hDEADBEEF);

    // Copy with destination wrap; mem[0] is overwritten after being read.
    issue(2'b10, 32'd0, 32'd30, 6'd4, 32'd0, -1, acc);
    wait_done();
    chk("cpwrap_m30", mem[30], 32'd7);
    chk("cpwrap_m31", mem[31], 32'd5);
    chk("cpwrap_m0", mem[0], 32'd2);
    chk("cpwrap_m1", mem[1], 32'd4);
    chk("cpwrap_latency", 32'(seen_cyc - acc), 32'd9);
    chk("cpwrap_rdata", seen_rdata, 32'd4);

    // Overlapping copy replicates the source word.
    issue(2'b01, 32'd0, 32'd0, 6'd0, 32'd7, -1, acc);
    wait_done();
    issue(2'b10, 32'd0, 32'd1, 6'd3, 32'd0, -1, acc);
    wait_done();
    chk("overlap_m1", mem[1], 32'd7);
    chk("overlap_m2", mem[2], 32'd7);
    chk("overlap_m3", mem[3], 32'd7);

    // Illegal commands: error after one cycle, no strobes, rdata retained.
    for (int k = 0; k < 3; k++) begin
      r0 = rd_cnt + wr_cnt;
      if (k == 0)      issue(2'b10, 32'd5, 32'd9, 6'd0, 32'd0, -1, acc);
      else if (k == 1) issue(2'b10, 32'd5, 32'd9, 6'd33, 32'd0, -1, acc);
      else             issue(2'b11, 32'd5, 32'd9, 6'd2, 32'd0, -1, acc);
      wait_done();
      chk("illegal_err", 32'(seen_err), 32'd1);
      chk("illegal_latency", 32'(seen_cyc - acc), 32'd1);
      chk("illegal_strobes", 32'(rd_cnt + wr_cnt - r0), 32'd0);
      chk("illegal_keeps_rdata", seen_rdata, 32'd7);
    end

    // Read held while a 5-word copy runs: accepted on the first idle edge.
    issue(2'b10, 32'd4, 32'd12, 6'd5, 32'd0, -1, acc);
    issue(2'b00, 32'd13, 32'd0, 6'd0, 32'd0, -1, acc2);
    chk("held_accept_cycle", 32'(acc2 - acc), 32'd12);
    wait_done();

    // Reset during the third write of an 8-word copy.
    snap = mem;
    issue(2'b10, 32'd8, 32'd20, 6'd8, 32'd0, 2, acc);
    repeat (6) @(negedge clock);
    #2 nReset = 1'b0;
    #1;
    last_rdata = '0;
    chk("midrst_ctrl", 32'({cmd_ready, busy, resp_valid, resp_err, memRead, memWrite}), 32'b100000);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_addr", memAddress, 32'd0);
    chk("midrst_wdata", memWriteData, 32'd0);
    chk("midrst_strobes_left", 32'(sq.size()), 32'd0);
    repeat (2) @(negedge clock);
    #2 nReset = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    diffs = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== snap[i]) diffs++;
    chk("midrst_words_modified", 32'(diffs), 32'd2);
    chk("midrst_m20", mem[20], snap[8]);
    chk("midrst_m21", mem[21], snap[9]);
    chk("midrst_m22", mem[22], snap[22]);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 2'b00;
        3, 4, 5: op = 2'b01;
        6, 7, 8: op = 2'b10;
        default: op = 2'b11;
      endcase
      issue(op, $urandom, $urandom, 6'($urandom_range(0, 34)), $urandom, -1, acc);
      if ($urandom_range(0, 3) == 0) wait_done();
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_done();

    for (int i = 0; i < int'(DEPTH); i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
